i2s_mic_rx: RTL and testbench

I2S microphone receiver that generates the bit clock and word select for a digital MEMS microphone. It deserializes one selected channel into 16-bit samples and pushes each sample into the downstream mic sample FIFO through that FIFO's write port (`wr_en`, `din`, `full`). It sits between the microphone pins and the mic buffer in the Signal Processing front end.

---
 rtl/i2s_mic_rx.sv | 123 ++++++++++++
 tb/tb_i2s_mic_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx
//   I2S master receiver for a digital MEMS microphone. Generates the bit
//   clock (sck) and word select (ws), deserializes the 16 MSBs of one slot
//   (CH_SEL: 0 = left/ws low, 1 = right/ws high) and writes each finished
//   sample into the downstream FIFO's write port.
//
// Parameters
//   CLK_DIV  clk cycles per sck half-period (>= 2)
//   CH_SEL   captured slot, 0 = left, 1 = right
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   en       capture enable; low returns the block to idle on the next edge
//   sck      I2S bit clock to the mic
//   ws       I2S word select to the mic
//   sd       serial data from the mic, launched on sck falling edges
//   full     FIFO full flag, looked at only on the push edge
//   wr_en    one-cycle FIFO write strobe
//   din      sample to the FIFO, valid while wr_en is high
//   ovf_cnt  saturating count of samples dropped because full was high
module i2s_mic_rx #(
  parameter int CLK_DIV = 4,
  parameter int CH_SEL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        sck,
  output logic        ws,
  input  logic        sd,
  input  logic        full,
  output logic        wr_en,
  output logic [15:0] din,
  output logic [15:0] ovf_cnt
);

  localparam int            DW      = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic          CH      = 1'(CH_SEL);

  // en is registered once: the divider runs off en_q, so an en sampled at
  // edge N takes effect at edge N+1 (both for start-up and for shutdown).
  logic          en_q;
  logic [DW-1:0] div;
  logic [5:0]    bit_cnt;
  logic [15:0]   shreg;

  logic          div_wrap;
  logic          rise;
  logic          fall;
  logic [4:0]    slot_bit;
  logic          in_slot;
  logic          cap;
  logic          push;
  logic [15:0]   next_word;

  assign div_wrap  = (div == DIV_MAX);
  assign rise      = div_wrap & ~sck;
  assign fall      = div_wrap & sck;
  assign slot_bit  = bit_cnt[4:0];
  assign in_slot   = (bit_cnt[5] == CH);
  // One-bit I2S delay: slot bit 1 carries the MSB, bit 16 the LSB.
  assign cap       = rise & in_slot & (slot_bit >= 5'd1) & (slot_bit <= 5'd16);
  assign push      = rise & in_slot & (slot_bit == 5'd16);
  assign next_word = {shreg[14:0], sd};

  // ws follows the frame counter MSB; bit_cnt only moves on sck falls, so
  // ws is stable across every rise where sd is sampled.
  assign ws = bit_cnt[5];

  // sd is sampled half an sck period after the mic launches it, so it is
  // settled at the sampling edge and needs no extra synchronizer stages
  // (which would also eat into the half-period for small CLK_DIV).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      div     <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      en_q <= en;
      if (!en_q) begin
        div     <= '0;
        sck     <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        if (div_wrap) begin
          div <= '0;
          sck <= ~sck;
        end else begin
          div <= div + 1'b1;
        end
        if (fall) bit_cnt <= bit_cnt + 6'd1;
        if (cap)  shreg   <= next_word;
      end
    end
  end

  // Push stage. The word handed to the FIFO includes the bit sampled on
  // this very edge, hence next_word rather than shreg. A full FIFO drops
  // the sample outright: no retry, din keeps the last delivered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      din     <= '0;
      ovf_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (en_q && push) begin
        if (!full) begin
          wr_en <= 1'b1;
          din   <= next_word;
        end else if (ovf_cnt != 16'hFFFF) begin
          ovf_cnt <= ovf_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx. Two instances (left and right slot) share the same
// mic line. The reference model works from absolute edge time t since en
// was first sampled high: sck/ws/push times follow directly from the
// frame arithmetic, and the mic drives each slot word from that same clock.
module tb_i2s_mic_rx;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sd = 1'b1;
  logic        full = 1'b0;
  logic        sck [2];
  logic        ws [2];
  logic        wr_en [2];
  logic [15:0] din [2];
  logic [15:0] ovf [2];

  always #5 clk = ~clk;

  i2s_mic_rx #(.CLK_DIV(CD), .CH_SEL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .sck(sck[0]), .ws(ws[0]), .sd(sd),
    .full(full), .wr_en(wr_en[0]), .din(din[0]), .ovf_cnt(ovf[0]));

  i2s_mic_rx #(.CLK_DIV(CD), .CH_SEL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sck(sck[1]), .ws(ws[1]), .sd(sd),
    .full(full), .wr_en(wr_en[1]), .din(din[1]), .ovf_cnt(ovf[1]));

  int          tests = 0;
  int          fails = 0;
  int          t = -1;
  bit          en_prev = 1'b0;
  bit          wr_exp [2];
  logic [15:0] din_exp [2];
  logic [15:0] ovf_exp [2];
  logic [15:0] left_w = 16'hFFFF;
  logic [15:0] right_w = 16'hFFFF;
  bit          rnd_fill = 1'b0;
  bit          rnd_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_push(input int tt, input int ch);
    int k;
    k = tt / (2 * CD);
    return (tt % (2 * CD) == CD) && (k % 32 == 16) && ((k / 32) % 2 == ch);
  endfunction

  task automatic drive_inputs();
    int k, s;
    logic [15:0] w;
    if (rst && t >= 0) begin
      k = t / (2 * CD);
      s = k % 32;
      w = ((k / 32) % 2 == 1) ? right_w : left_w;
      if (s >= 1 && s <= 16) sd = w[16 - s];
      else sd = rnd_fill ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      sd = rnd_fill ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (rnd_full) full = ($urandom_range(0, 7) == 0);
  endtask

  task automatic step();
    bit act;
    act = 1'b0;
    @(posedge clk);
    wr_exp[0] = 1'b0;
    wr_exp[1] = 1'b0;
    if (!rst) begin
      en_prev = 1'b0;
      t = -1;
      for (int ch = 0; ch < 2; ch++) begin
        din_exp[ch] = 16'h0;
        ovf_exp[ch] = 16'h0;
      end
    end else begin
      if (en_prev) begin
        t++;
        act = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
          if (is_push(t, ch)) begin
            if (full) begin
              if (ovf_exp[ch] != 16'hFFFF) ovf_exp[ch]++;
            end else begin
              wr_exp[ch]  = 1'b1;
              din_exp[ch] = (ch == 1) ? right_w : left_w;
            end
          end
        end
      end else begin
        t = en ? 0 : -1;
      end
      en_prev = en;
    end
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("sck[%0d] t=%0d", ch, t), sck[ch], act ? (t / CD) % 2 : 0);
      chk($sformatf("ws[%0d] t=%0d", ch, t), ws[ch], act ? ((t / (2 * CD)) / 32) % 2 : 0);
      chk($sformatf("wr_en[%0d] t=%0d", ch, t), wr_en[ch], wr_exp[ch]);
      chk($sformatf("din[%0d] t=%0d", ch, t), din[ch], din_exp[ch]);
      chk($sformatf("ovf[%0d] t=%0d", ch, t), ovf[ch], ovf_exp[ch]);
    end
    drive_inputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      wr_exp[ch]  = 1'b0;
      din_exp[ch] = 16'h0;
      ovf_exp[ch] = 16'h0;
    end

    // Reset with en low, then idle for 1000 cycles.
    #1 rst = 1'b0;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("rst_sck[%0d]", ch), sck[ch], 0);
      chk($sformatf("rst_wr[%0d]", ch), wr_en[ch], 0);
      chk($sformatf("rst_din[%0d]", ch), din[ch], 0);
    end
    steps(3);
    rst = 1'b1;
    steps(1000);

    // Left word A5C3, all other bits high.
    left_w  = 16'hA5C3;
    right_w = 16'hFFFF;
    en = 1'b1;
    steps(1200);

    // Left 1234, right BEEF.
    en = 1'b0;
    steps(10);
    left_w  = 16'h1234;
    right_w = 16'hBEEF;
    en = 1'b1;
    steps(1000);

    // full held over three push edges of each slot, then released.
    en = 1'b0;
    steps(5);
    en = 1'b1;
    steps(100);
    full = 1'b1;
    steps(1536);
    full = 1'b0;
    steps(1100);
    chk("ovf_after_full[0]", ovf[0], 3);
    chk("ovf_after_full[1]", ovf[1], 3);

    // en dropped at edge 100, restored at edge 200.
    en = 1'b0;
    steps(5);
    left_w   = 16'($urandom);
    right_w  = 16'($urandom);
    rnd_fill = 1'b1;
    en = 1'b1;
    steps(100);
    en = 1'b0;
    steps(100);
    en = 1'b1;
    steps(700);

    // Random words, filler bits and full.
    for (int r = 0; r < 3; r++) begin
      en = 1'b0;
      rnd_full = 1'b0;
      full = 1'b0;
      steps($urandom_range(3, 20));
      left_w  = 16'($urandom);
      right_w = 16'($urandom);
      en = 1'b1;
      rnd_full = 1'b1;
      steps(1100);
    end
    rnd_full = 1'b0;
    full = 1'b0;

    // Async reset during the edge-132 wr_en cycle.
    en = 1'b0;
    steps(3);
    en = 1'b1;
    steps(133);
    #1 rst = 1'b0;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("arst_wr[%0d]", ch), wr_en[ch], 0);
      chk($sformatf("arst_sck[%0d]", ch), sck[ch], 0);
      chk($sformatf("arst_ws[%0d]", ch), ws[ch], 0);
      chk($sformatf("arst_ovf[%0d]", ch), ovf[ch], 0);
      chk($sformatf("arst_din[%0d]", ch), din[ch], 0);
    end
    steps(3);
    rst = 1'b1;
    steps(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
